// File: rtl/la_acq_trg_if.sv
// Sample stream bundle for the acquisition controller: unthrottled sample input (sti_*)
// and the registered valid/ready output stream (sto_*).
interface la_acq_trg_if #(
  parameter int unsigned DW = 16
);
  logic [DW-1:0] sti_dat;
  logic          sti_vld;
  logic [DW-1:0] sto_dat;
  logic          sto_vld;
  logic          sto_rdy;
  logic          sto_lst;

  modport slave (
    input  sti_dat, sti_vld, sto_rdy,
    output sto_dat, sto_vld, sto_lst
  );

  modport master (
    output sti_dat, sti_vld, sto_rdy,
    input  sto_dat, sto_vld, sto_lst
  );
endinterface

// File: rtl/la_acq_trg.sv
// Logic-analyzer acquisition/trigger controller: pre/post counting, level/edge/external
// triggers with Nth-occurrence and auto modes, single-register output stream with overflow.
module la_acq_trg #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 32,
  parameter int unsigned TW = 4,
  parameter int unsigned HW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ctl_rst,
  input  logic          ctl_acq,
  input  logic          ctl_stp,
  input  logic          cfg_aut,
  input  logic [TW-1:0] cfg_trg_src,
  input  logic [DW-1:0] cfg_cmp_msk,
  input  logic [DW-1:0] cfg_cmp_val,
  input  logic [DW-1:0] cfg_edg_pos,
  input  logic [DW-1:0] cfg_edg_neg,
  input  logic [CW-1:0] cfg_pre,
  input  logic [CW-1:0] cfg_pst,
  input  logic [HW-1:0] cfg_hit,
  input  logic [TW-2:0] ext_trg,
  la_acq_trg_if.slave   smp,
  output logic          sts_run,
  output logic          sts_trg,
  output logic          sts_ovf,
  output logic [CW-1:0] sts_cnt_pre,
  output logic [CW-1:0] sts_cnt_pst,
  output logic          trg_out
);

  typedef enum logic [1:0] {StIdle, StPre, StArm, StPost} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_pre_q, cnt_pre_d, cnt_pst_q, cnt_pst_d;
  logic [HW-1:0] hit_q, hit_d;
  logic          trg_q, trg_d, ovf_q, ovf_d, tpl_q, tpl_d;
  logic [DW-1:0] prv_q, prv_d, dat_q, dat_d;
  logic          vld_q, vld_d, lst_q, lst_d;

  logic          lvl, edg, int_ev, qev, fwd, last;
  logic [CW-1:0] pre_inc, pst_inc;
  logic [HW-1:0] hit_inc;

  assign lvl = ~|((smp.sti_dat ^ cfg_cmp_val) & cfg_cmp_msk);
  // With no edge enables the edge term must not block the level compare.
  assign edg = ~|(cfg_edg_pos | cfg_edg_neg)
             | (|(cfg_edg_pos & smp.sti_dat & ~prv_q))
             | (|(cfg_edg_neg & ~smp.sti_dat & prv_q));
  assign int_ev = lvl & edg & smp.sti_vld;
  assign qev    = |(cfg_trg_src & {ext_trg, int_ev});

  assign pre_inc = (&cnt_pre_q) ? cnt_pre_q : cnt_pre_q + CW'(1);
  assign pst_inc = (&cnt_pst_q) ? cnt_pst_q : cnt_pst_q + CW'(1);
  assign hit_inc = (&hit_q) ? hit_q : hit_q + HW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_pre_d = cnt_pre_q;
    cnt_pst_d = cnt_pst_q;
    hit_d     = hit_q;
    trg_d     = trg_q;
    ovf_d     = ovf_q;
    tpl_d     = 1'b0;
    prv_d     = smp.sti_vld ? smp.sti_dat : prv_q;
    dat_d     = dat_q;
    vld_d     = vld_q & ~smp.sto_rdy;
    lst_d     = lst_q;
    fwd       = 1'b0;
    last      = 1'b0;

    if (ctl_rst) begin
      state_d   = StIdle;
      cnt_pre_d = '0;
      cnt_pst_d = '0;
      hit_d     = '0;
      trg_d     = 1'b0;
      ovf_d     = 1'b0;
      prv_d     = '0;
      dat_d     = '0;
      vld_d     = 1'b0;
      lst_d     = 1'b0;
    end else if (ctl_stp) begin
      // Counters and any pending output survive a stop.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (ctl_acq) begin
            state_d   = StPre;
            cnt_pre_d = '0;
            cnt_pst_d = '0;
            hit_d     = '0;
            trg_d     = 1'b0;
          end
        end
        StPre: begin
          if (smp.sti_vld) begin
            fwd       = 1'b1;
            cnt_pre_d = pre_inc;
          end
          if (cnt_pre_q >= cfg_pre) state_d = StArm;
        end
        StArm: begin
          if (smp.sti_vld) begin
            fwd       = 1'b1;
            cnt_pre_d = pre_inc;
          end
          if (qev) hit_d = hit_inc;
          if (cfg_aut || (qev && (hit_q == cfg_hit))) begin
            trg_d = 1'b1;
            tpl_d = 1'b1;
            if (cfg_pst == '0) begin
              state_d = StIdle;
              last    = smp.sti_vld;
            end else begin
              state_d = StPost;
            end
          end
        end
        StPost: begin
          if (smp.sti_vld) begin
            fwd       = 1'b1;
            cnt_pst_d = pst_inc;
            if (pst_inc >= cfg_pst) begin
              last    = 1'b1;
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase

      if (fwd) begin
        if (!vld_q || smp.sto_rdy) begin
          dat_d = smp.sti_dat;
          vld_d = 1'b1;
          lst_d = last;
        end else begin
          // Dropped sample still ends the run: tag the one already waiting.
          ovf_d = 1'b1;
          lst_d = lst_q | last;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      cnt_pre_q <= '0;
      cnt_pst_q <= '0;
      hit_q     <= '0;
      trg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      tpl_q     <= 1'b0;
      prv_q     <= '0;
      dat_q     <= '0;
      vld_q     <= 1'b0;
      lst_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_pre_q <= cnt_pre_d;
      cnt_pst_q <= cnt_pst_d;
      hit_q     <= hit_d;
      trg_q     <= trg_d;
      ovf_q     <= ovf_d;
      tpl_q     <= tpl_d;
      prv_q     <= prv_d;
      dat_q     <= dat_d;
      vld_q     <= vld_d;
      lst_q     <= lst_d;
    end
  end

  assign sts_run     = (state_q != StIdle);
  assign sts_trg     = trg_q;
  assign sts_ovf     = ovf_q;
  assign sts_cnt_pre = cnt_pre_q;
  assign sts_cnt_pst = cnt_pst_q;
  assign trg_out     = tpl_q;
  assign smp.sto_dat = dat_q;
  assign smp.sto_vld = vld_q;
  assign smp.sto_lst = lst_q;

endmodule
